liteic_axil_window_bridge: RTL

LITEIC_AXIL_WINDOW_BRIDGE -- requirements
Module: liteic_axil_window_bridge

---
 rtl/liteic_axil_window_bridge.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/liteic_axil_window_bridge.sv
// AXI-Lite address-window bridge: forwards transactions inside one aligned window
// downstream with the window offset, answers everything else locally with DECERR.
module liteic_axil_window_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    SLV_ADDR_WIDTH = 20,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    RESP_WIDTH     = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0010_0000,
    parameter int                    CNT_WIDTH      = 8,
    localparam int                   STRB_WIDTH     = (DATA_WIDTH + 7) / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic [ADDR_WIDTH-1:0]     s_ar_addr,
    input  logic [3:0]                s_ar_qos,
    input  logic                      s_ar_valid,
    output logic                      s_ar_ready,
    output logic [DATA_WIDTH-1:0]     s_r_data,
    output logic [RESP_WIDTH-1:0]     s_r_resp,
    output logic                      s_r_valid,
    input  logic                      s_r_ready,

    input  logic [ADDR_WIDTH-1:0]     s_aw_addr,
    input  logic [3:0]                s_aw_qos,
    input  logic                      s_aw_valid,
    output logic                      s_aw_ready,
    input  logic [DATA_WIDTH-1:0]     s_w_data,
    input  logic [STRB_WIDTH-1:0]     s_w_strb,
    input  logic                      s_w_valid,
    output logic                      s_w_ready,
    output logic [RESP_WIDTH-1:0]     s_b_resp,
    output logic                      s_b_valid,
    input  logic                      s_b_ready,

    output logic [SLV_ADDR_WIDTH-1:0] m_ar_addr,
    output logic [3:0]                m_ar_qos,
    output logic                      m_ar_valid,
    input  logic                      m_ar_ready,
    input  logic [DATA_WIDTH-1:0]     m_r_data,
    input  logic [RESP_WIDTH-1:0]     m_r_resp,
    input  logic                      m_r_valid,
    output logic                      m_r_ready,

    output logic [SLV_ADDR_WIDTH-1:0] m_aw_addr,
    output logic [3:0]                m_aw_qos,
    output logic                      m_aw_valid,
    input  logic                      m_aw_ready,
    output logic [DATA_WIDTH-1:0]     m_w_data,
    output logic [STRB_WIDTH-1:0]     m_w_strb,
    output logic                      m_w_valid,
    input  logic                      m_w_ready,
    input  logic [RESP_WIDTH-1:0]     m_b_resp,
    input  logic                      m_b_valid,
    output logic                      m_b_ready,

    output logic [CNT_WIDTH-1:0]      err_cnt_o
);

    localparam logic [RESP_WIDTH-1:0] RESP_DECERR = '1;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_FWD, W_BWAIT, W_RESP} wr_state_t;

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;

    logic                      accept_en;
    logic                      ar_hit, aw_hit;
    logic                      ar_hs, wr_hs;
    logic                      rd_miss, wr_miss;
    logic                      aw_done, w_done;
    logic                      fwd_done;

    logic [SLV_ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [3:0]                rd_qos, wr_qos;
    logic [DATA_WIDTH-1:0]     rd_data, wr_data;
    logic [STRB_WIDTH-1:0]     wr_strb;
    logic [RESP_WIDTH-1:0]     rd_resp, wr_resp;

    logic [1:0]                miss_inc;
    logic [CNT_WIDTH:0]        err_sum;

    assign ar_hit = (s_ar_addr[ADDR_WIDTH-1:SLV_ADDR_WIDTH] == BASE_ADDR[ADDR_WIDTH-1:SLV_ADDR_WIDTH]);
    assign aw_hit = (s_aw_addr[ADDR_WIDTH-1:SLV_ADDR_WIDTH] == BASE_ADDR[ADDR_WIDTH-1:SLV_ADDR_WIDTH]);

    assign ar_hs   = (rd_state == R_IDLE) && accept_en && s_ar_valid;
    assign wr_hs   = (wr_state == W_IDLE) && accept_en && s_aw_valid && s_w_valid;
    assign rd_miss = ar_hs && !ar_hit;
    assign wr_miss = wr_hs && !aw_hit;

    assign fwd_done = (aw_done || m_aw_ready) && (w_done || m_w_ready);

    assign s_r_data  = rd_data;
    assign s_r_resp  = rd_resp;
    assign s_b_resp  = wr_resp;
    assign m_ar_addr = rd_addr;
    assign m_ar_qos  = rd_qos;
    assign m_aw_addr = wr_addr;
    assign m_aw_qos  = wr_qos;
    assign m_w_data  = wr_data;
    assign m_w_strb  = wr_strb;

    // Upstream readies stay low until the first clock edge after reset release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            accept_en <= 1'b0;
        end else begin
            accept_en <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
        end
    end

    always_comb begin
        rd_next    = rd_state;
        s_ar_ready = 1'b0;
        m_ar_valid = 1'b0;
        m_r_ready  = 1'b0;
        s_r_valid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_ar_ready = accept_en;
                if (ar_hs) begin
                    rd_next = ar_hit ? R_ADDR : R_RESP;
                end
            end
            R_ADDR: begin
                m_ar_valid = 1'b1;
                if (m_ar_ready) begin
                    rd_next = R_DATA;
                end
            end
            R_DATA: begin
                m_r_ready = 1'b1;
                if (m_r_valid) begin
                    rd_next = R_RESP;
                end
            end
            R_RESP: begin
                s_r_valid = 1'b1;
                if (s_r_ready) begin
                    rd_next = R_IDLE;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        wr_next    = wr_state;
        s_aw_ready = 1'b0;
        s_w_ready  = 1'b0;
        m_aw_valid = 1'b0;
        m_w_valid  = 1'b0;
        m_b_ready  = 1'b0;
        s_b_valid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                s_aw_ready = wr_hs;
                s_w_ready  = wr_hs;
                if (wr_hs) begin
                    wr_next = aw_hit ? W_FWD : W_RESP;
                end
            end
            W_FWD: begin
                m_aw_valid = !aw_done;
                m_w_valid  = !w_done;
                if (fwd_done) begin
                    wr_next = W_BWAIT;
                end
            end
            W_BWAIT: begin
                m_b_ready = 1'b1;
                if (m_b_valid) begin
                    wr_next = W_RESP;
                end
            end
            W_RESP: begin
                s_b_valid = 1'b1;
                if (s_b_ready) begin
                    wr_next = W_IDLE;
                end
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // A miss preloads the DECERR reply so R_RESP serves both paths identically.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_addr <= '0;
            rd_qos  <= '0;
            rd_data <= '0;
            rd_resp <= '0;
        end else begin
            if (ar_hs) begin
                if (ar_hit) begin
                    rd_addr <= s_ar_addr[SLV_ADDR_WIDTH-1:0];
                    rd_qos  <= s_ar_qos;
                end else begin
                    rd_data <= '0;
                    rd_resp <= RESP_DECERR;
                end
            end
            if ((rd_state == R_DATA) && m_r_valid) begin
                rd_data <= m_r_data;
                rd_resp <= m_r_resp;
            end
        end
    end

    // AW and W complete independently; the done flags remember which one has gone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_addr <= '0;
            wr_qos  <= '0;
            wr_data <= '0;
            wr_strb <= '0;
            wr_resp <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (wr_hs) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (aw_hit) begin
                    wr_addr <= s_aw_addr[SLV_ADDR_WIDTH-1:0];
                    wr_qos  <= s_aw_qos;
                    wr_data <= s_w_data;
                    wr_strb <= s_w_strb;
                end else begin
                    wr_resp <= RESP_DECERR;
                end
            end
            if (m_aw_valid && m_aw_ready) begin
                aw_done <= 1'b1;
            end
            if (m_w_valid && m_w_ready) begin
                w_done <= 1'b1;
            end
            if ((wr_state == W_BWAIT) && m_b_valid) begin
                wr_resp <= m_b_resp;
            end
        end
    end

    assign miss_inc = {1'b0, rd_miss} + {1'b0, wr_miss};
    assign err_sum  = {1'b0, err_cnt_o} + {{(CNT_WIDTH-1){1'b0}}, miss_inc};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (err_sum[CNT_WIDTH]) begin
            err_cnt_o <= '1;
        end else begin
            err_cnt_o <= err_sum[CNT_WIDTH-1:0];
        end
    end

endmodule
